reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the CC core: NUM_RD read ports, NUM_WR write ports.

---
 rtl/reg_file_mp_pkg.sv | 21 ++
 rtl/reg_file_mp_if.sv | 33 +++
 rtl/reg_file_clear_fsm.sv | 68 ++++++
 rtl/reg_file_mp.sv | 122 ++++++++++++
 tb/tb_reg_file_mp.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 2;
    localparam int DEF_BYPASS   = 1;

    // Bulk-clear engine states.
    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    // Register address width for a file of n registers.
    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Port bundle between issue/writeback logic (master) and the register file (slave).
interface reg_file_mp_if #(
    parameter int DATA_W   = reg_file_pkg::DEF_DATA_W,
    parameter int NUM_REGS = reg_file_pkg::DEF_NUM_REGS,
    parameter int NUM_RD   = reg_file_pkg::DEF_NUM_RD,
    parameter int NUM_WR   = reg_file_pkg::DEF_NUM_WR
) ();

    localparam int AW = reg_file_pkg::addr_w(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     pend_set;
    logic [AW-1:0]            pend_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_req,
        input  rd_data, rd_pending, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_req,
        output rd_data, rd_pending, clr_busy, clr_done
    );

endinterface

// File: rtl/reg_file_clear_fsm.sv
// Sequential bulk-clear engine: walks registers 1..NUM_REGS-1, one per cycle.
// Register 0 is hardwired to zero, so the walk starts at index 1.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int AW       = addr_w(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active-low
    input  logic          i_clr_req,
    output logic          o_clr_busy, // also the per-cycle clear strobe
    output logic          o_clr_done,
    output logic [AW-1:0] o_clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] PREV_IDX = AW'(NUM_REGS - 2);

    clr_state_e    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    // State, index counter and registered busy/done flags.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr_req) begin
                        r_state <= CLR_RUN;
                        r_cnt   <= AW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= CLR_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + AW'(1);
                        // done is raised for the cycle that clears the last register
                        r_done <= (r_cnt == PREV_IDX);
                    end
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_clr_done = r_done;
    assign o_clr_idx  = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register pending bits, optional
// write->read bypass and a sequential bulk-clear engine.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic         clk,
    input  logic         reset,   // asynchronous, active-low
    reg_file_mp_if.slave bus
);

    localparam int AW = addr_w(NUM_REGS);

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]      r_pend;

    logic                     w_busy;
    logic                     w_done;
    logic [AW-1:0]            w_clr_idx;

    logic [NUM_REGS-1:0]      w_wr_hit;
    logic [DATA_W-1:0]        w_wr_val [NUM_REGS];
    logic                     w_pset;

    logic [AW-1:0]            w_ra [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_pend;

    reg_file_clear_fsm #(.NUM_REGS(NUM_REGS)) u_clear (
        .clk        (clk),
        .reset      (reset),
        .i_clr_req  (bus.clr_req),
        .o_clr_busy (w_busy),
        .o_clr_done (w_done),
        .o_clr_idx  (w_clr_idx)
    );

    // Resolve the winning write per register: ascending scan lets the higher port override.
    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch forms.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_val[i] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == AW'(i))) begin
                    w_wr_hit[i] = 1'b1;
                    w_wr_val[i] = bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
            // register 0 is constant and the clear engine owns the array while busy
            if (i == 0 || w_busy) begin
                w_wr_hit[i] = 1'b0;
            end
        end
    end

    assign w_pset = bus.pend_set && !w_busy && (bus.pend_addr != '0);

    // Read muxes, with same-cycle bypass of the winning write when enabled.
    always_comb begin
        w_rd_data = '0;
        w_rd_pend = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra[p] = bus.rd_addr[p*AW +: AW];
            if (w_ra[p] != '0) begin
                if ((BYPASS != 0) && w_wr_hit[w_ra[p]]) begin
                    w_rd_data[p*DATA_W +: DATA_W] = w_wr_val[w_ra[p]];
                    w_rd_pend[p] = w_pset && (bus.pend_addr == w_ra[p]);
                end else begin
                    w_rd_data[p*DATA_W +: DATA_W] = r_regs[w_ra[p]];
                    w_rd_pend[p] = r_pend[w_ra[p]];
                end
            end
        end
    end

    // Storage array: clear engine first, then the resolved write.
    // NOTE: the array is reset because reset must leave every register reading zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_busy && (w_clr_idx == AW'(i))) begin
                    r_regs[i] <= '0;
                end else if (w_wr_hit[i]) begin
                    r_regs[i] <= w_wr_val[i];
                end
            end
        end
    end

    // Pending bits: clear engine, then pend_set (wins over a same-cycle write), then write clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_busy && (w_clr_idx == AW'(i))) begin
                    r_pend[i] <= 1'b0;
                end else if (w_pset && (bus.pend_addr == AW'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (w_wr_hit[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_data    = w_rd_data;
    assign bus.rd_pending = w_rd_pend;
    assign bus.clr_busy   = w_busy;
    assign bus.clr_done   = w_done;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing instance and one non-bypassing instance.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus_a ();
    reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus_b ();

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic idle_all();
        bus_a.rd_addr = '0; bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.pend_set = 1'b0; bus_a.pend_addr = '0; bus_a.clr_req = 1'b0;
        bus_b.rd_addr = '0; bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.pend_set = 1'b0; bus_b.pend_addr = '0; bus_b.clr_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_a.wr_en[port]             = 1'b1;
        bus_a.wr_addr[port*AW +: AW]  = a;
        bus_a.wr_data[port*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] a);
        bus_a.rd_addr[port*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd_a(input int port);
        return bus_a.rd_data[port*DW +: DW];
    endfunction

    task automatic test_reset();
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_held: got %b want 0", bus_a.clr_busy); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NR; i += 2) begin
            set_rd(0, AW'(i));
            set_rd(1, AW'(i + 1));
            #1;
            total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL rst_data r%0d: got %h want 0", i, rd_a(0)); end
            total++; if (rd_a(1) !== 32'h0) begin bad++; $display("FAIL rst_data r%0d: got %h want 0", i + 1, rd_a(1)); end
            total++; if (bus_a.rd_pending !== 2'b00) begin bad++; $display("FAIL rst_pend r%0d: got %b want 00", i, bus_a.rd_pending); end
        end
        total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_a.clr_busy); end
        total++; if (bus_a.clr_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus_a.clr_done); end
    endtask

    task automatic test_write_priority();
        step();
        idle_all();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        set_wr(1, 5'd5, 32'h1234_5678);
        set_rd(0, 5'd5);
        #1;
        total++; if (rd_a(0) !== 32'h1234_5678) begin bad++; $display("FAIL prio_bypass: got %h want 12345678", rd_a(0)); end
        step();
        idle_all();
        set_rd(0, 5'd5);
        #1;
        total++; if (rd_a(0) !== 32'h1234_5678) begin bad++; $display("FAIL prio_stored: got %h want 12345678", rd_a(0)); end
        // distinct addresses on both ports both commit
        set_wr(0, 5'd6, 32'h0000_1111);
        set_wr(1, 5'd8, 32'h0000_2222);
        step();
        idle_all();
        set_rd(0, 5'd6);
        set_rd(1, 5'd8);
        #1;
        total++; if (rd_a(0) !== 32'h0000_1111) begin bad++; $display("FAIL dual_wr_r6: got %h want 00001111", rd_a(0)); end
        total++; if (rd_a(1) !== 32'h0000_2222) begin bad++; $display("FAIL dual_wr_r8: got %h want 00002222", rd_a(1)); end
    endtask

    task automatic test_bypass();
        idle_all();
        set_wr(0, 5'd7, 32'hA5A5_A5A5);
        set_rd(0, 5'd7);
        bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0 +: AW] = 5'd7; bus_b.wr_data[0 +: DW] = 32'hA5A5_A5A5;
        bus_b.rd_addr[0 +: AW] = 5'd7;
        #1;
        total++; if (rd_a(0) !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp1_same: got %h want a5a5a5a5", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b0) begin bad++; $display("FAIL byp1_pend: got %b want 0", bus_a.rd_pending[0]); end
        total++; if (bus_b.rd_data[0 +: DW] !== 32'h0) begin bad++; $display("FAIL byp0_same: got %h want 0", bus_b.rd_data[0 +: DW]); end
        step();
        idle_all();
        set_rd(0, 5'd7);
        bus_b.rd_addr[0 +: AW] = 5'd7;
        #1;
        total++; if (bus_b.rd_data[0 +: DW] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp0_next: got %h want a5a5a5a5", bus_b.rd_data[0 +: DW]); end
        total++; if (rd_a(0) !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp1_next: got %h want a5a5a5a5", rd_a(0)); end
    endtask

    task automatic test_pending();
        idle_all();
        bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd9;
        set_rd(0, 5'd9);
        #1;
        total++; if (bus_a.rd_pending[0] !== 1'b0) begin bad++; $display("FAIL pend_before: got %b want 0", bus_a.rd_pending[0]); end
        step();
        idle_all();
        set_rd(0, 5'd9);
        #1;
        total++; if (bus_a.rd_pending[0] !== 1'b1) begin bad++; $display("FAIL pend_set: got %b want 1", bus_a.rd_pending[0]); end
        set_wr(1, 5'd9, 32'h42);
        #1;
        total++; if (rd_a(0) !== 32'h42) begin bad++; $display("FAIL pend_wr_byp_data: got %h want 42", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b0) begin bad++; $display("FAIL pend_wr_byp_pend: got %b want 0", bus_a.rd_pending[0]); end
        step();
        idle_all();
        set_rd(0, 5'd9);
        #1;
        total++; if (rd_a(0) !== 32'h42) begin bad++; $display("FAIL pend_wr_data: got %h want 42", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b0) begin bad++; $display("FAIL pend_wr_clear: got %b want 0", bus_a.rd_pending[0]); end
        set_wr(0, 5'd9, 32'h99);
        bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd9;
        #1;
        total++; if (rd_a(0) !== 32'h99) begin bad++; $display("FAIL both_byp_data: got %h want 99", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b1) begin bad++; $display("FAIL both_byp_pend: got %b want 1", bus_a.rd_pending[0]); end
        step();
        idle_all();
        set_rd(0, 5'd9);
        #1;
        total++; if (rd_a(0) !== 32'h99) begin bad++; $display("FAIL both_data: got %h want 99", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b1) begin bad++; $display("FAIL both_pend: got %b want 1", bus_a.rd_pending[0]); end
        bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd0;
        step();
        idle_all();
        set_rd(1, 5'd0);
        #1;
        total++; if (bus_a.rd_pending[1] !== 1'b0) begin bad++; $display("FAIL pend_r0: got %b want 0", bus_a.rd_pending[1]); end
    endtask

    task automatic test_clear();
        for (int i = 1; i < NR; i++) begin
            idle_all();
            set_wr(0, AW'(i), DW'(i));
            if (i == 3) begin
                bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd3;
            end
            step();
        end
        idle_all();
        set_rd(0, 5'd31);
        set_rd(1, 5'd3);
        #1;
        total++; if (rd_a(0) !== 32'd31) begin bad++; $display("FAIL fill_r31: got %h want 1f", rd_a(0)); end
        total++; if (rd_a(1) !== 32'd3) begin bad++; $display("FAIL fill_r3: got %h want 3", rd_a(1)); end
        total++; if (bus_a.rd_pending[1] !== 1'b1) begin bad++; $display("FAIL fill_pend_r3: got %b want 1", bus_a.rd_pending[1]); end
        bus_a.clr_req = 1'b1;
        step();
        for (int cyc = 0; cyc < 34; cyc++) begin
            total++; if (bus_a.clr_busy !== (cyc < 31)) begin bad++; $display("FAIL clr_busy c%0d: got %b want %b", cyc, bus_a.clr_busy, (cyc < 31)); end
            total++; if (bus_a.clr_done !== (cyc == 30)) begin bad++; $display("FAIL clr_done c%0d: got %b want %b", cyc, bus_a.clr_done, (cyc == 30)); end
            idle_all();
            if (cyc < 31) begin
                set_wr(0, 5'd31, 32'h0000_FFFF);
                set_wr(1, 5'd2, 32'h0000_BEEF);
                bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd31;
                bus_a.clr_req = (cyc >= 10 && cyc <= 20);
                set_rd(0, 5'd31);
                #1;
                total++; if (rd_a(0) !== 32'd31) begin bad++; $display("FAIL clr_rd_r31 c%0d: got %h want 1f", cyc, rd_a(0)); end
            end
            step();
        end
        idle_all();
        for (int i = 0; i < NR; i += 2) begin
            set_rd(0, AW'(i));
            set_rd(1, AW'(i + 1));
            #1;
            total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL cleared r%0d: got %h want 0", i, rd_a(0)); end
            total++; if (rd_a(1) !== 32'h0) begin bad++; $display("FAIL cleared r%0d: got %h want 0", i + 1, rd_a(1)); end
            total++; if (bus_a.rd_pending !== 2'b00) begin bad++; $display("FAIL cleared_pend r%0d: got %b want 00", i, bus_a.rd_pending); end
        end
    endtask

    task automatic test_clear_level();
        int n;
        idle_all();
        bus_a.clr_req = 1'b1;
        step();
        for (int cyc = 0; cyc < 33; cyc++) begin
            total++; if (bus_a.clr_busy !== (cyc != 31)) begin bad++; $display("FAIL lvl_busy c%0d: got %b want %b", cyc, bus_a.clr_busy, (cyc != 31)); end
            total++; if (bus_a.clr_done !== (cyc == 30)) begin bad++; $display("FAIL lvl_done c%0d: got %b want %b", cyc, bus_a.clr_done, (cyc == 30)); end
            step();
        end
        bus_a.clr_req = 1'b0;
        n = 0;
        while (bus_a.clr_busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL lvl_timeout: busy=%b after %0d cycles want 0", bus_a.clr_busy, n); end
    endtask

    task automatic test_reset_mid_clear();
        idle_all();
        set_wr(0, 5'd20, 32'h0000_CAFE);
        bus_a.pend_set = 1'b1; bus_a.pend_addr = 5'd25;
        step();
        idle_all();
        bus_a.clr_req = 1'b1;
        step();
        bus_a.clr_req = 1'b0;
        repeat (9) step();
        set_rd(0, 5'd20);
        #1;
        total++; if (rd_a(0) !== 32'h0000_CAFE) begin bad++; $display("FAIL mid_r20: got %h want cafe", rd_a(0)); end
        step();
        reset = 1'b0;
        #1;
        total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus_a.clr_busy); end
        total++; if (bus_a.clr_done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", bus_a.clr_done); end
        set_rd(0, 5'd20);
        set_rd(1, 5'd25);
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL abort_r20: got %h want 0", rd_a(0)); end
        total++; if (bus_a.rd_pending[1] !== 1'b0) begin bad++; $display("FAIL abort_pend_r25: got %b want 0", bus_a.rd_pending[1]); end
        @(negedge clk);
        reset = 1'b1;
        step();
        total++; if (bus_a.clr_busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", bus_a.clr_busy); end
        idle_all();
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_wr(1, 5'd0, 32'h8765_4321);
        set_rd(0, 5'd0);
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL r0_byp: got %h want 0", rd_a(0)); end
        step();
        idle_all();
        set_rd(0, 5'd0);
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL r0_stored: got %h want 0", rd_a(0)); end
        total++; if (bus_a.rd_pending[0] !== 1'b0) begin bad++; $display("FAIL r0_pend: got %b want 0", bus_a.rd_pending[0]); end
    endtask

    initial begin
        test_reset();
        test_write_priority();
        test_bypass();
        test_pending();
        test_clear();
        test_clear_level();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
